// File: rtl/passageway_ctrl.sv
// ---------------------------------------------------------------------------
// passageway_ctrl
//
// Purpose:
//   Corridor controller for the passageway benchmark. Each accepted step
//   consumes one tester move (iup / iright) and advances a registered corridor
//   state: door closed / open / doorstep, current zone 0..4, a stall counter
//   that raises a sticky fault when progress stops, and a sticky goal flag
//   once zone 4 is reached. Outputs feed the controllable_* inputs of the
//   passageway requirement monitor.
//
// Parameters:
//   STALL_LIMIT  consecutive non-advancing accepted steps before fault (>= 1)
//   CNT_W        width of the accepted-step counter
//
// Ports:
//   clk          single clock, rising edge
//   rst_n        asynchronous active-low reset
//   step         qualifies iup / iright as one move this cycle
//   restart      synchronous episode restart, beats step
//   iup          1 = up, 0 = down
//   iright       1 = right, 0 = left
//   zone0..zone4 one-hot current zone
//   open         door open (any state other than CLOSED)
//   doorstep     standing on the doorstep
//   fault        sticky stall fault
//   goal         sticky, zone 4 reached
//   step_cnt     accepted steps this episode, saturating
//
// Every output is decoded from registers only; there is no combinational
// path from any input to any output.
// ---------------------------------------------------------------------------
module passageway_ctrl #(
    parameter int STALL_LIMIT = 16,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             step,
    input  logic             restart,
    input  logic             iup,
    input  logic             iright,
    output logic             zone0,
    output logic             zone1,
    output logic             zone2,
    output logic             zone3,
    output logic             zone4,
    output logic             open,
    output logic             doorstep,
    output logic             fault,
    output logic             goal,
    output logic [CNT_W-1:0] step_cnt
);

    // Stall counter must be able to hold STALL_LIMIT itself, because it
    // saturates there once the fault is raised.
    localparam int STALL_W = $clog2(STALL_LIMIT + 1);

    // Door FSM encoding, kept as plain constants so older tools and
    // waveform scripts that decode the raw value keep working.
    localparam logic [1:0] CLOSED   = 2'd0;
    localparam logic [1:0] OPEN     = 2'd1;
    localparam logic [1:0] DOORSTEP = 2'd2;

    localparam logic [2:0]         ZONE_LAST     = 3'd4;
    localparam logic [STALL_W-1:0] STALL_MAX     = STALL_W'(STALL_LIMIT);
    localparam logic [STALL_W:0]   STALL_LIM_EXT = (STALL_W + 1)'(STALL_LIMIT);
    localparam logic [CNT_W-1:0]   CNT_MAX       = '1;

    logic [1:0]         state_q;
    logic [1:0]         state_d;
    logic [2:0]         zone_q;
    logic [2:0]         zone_d;
    logic [STALL_W-1:0] stall_q;
    logic [STALL_W:0]   stall_inc;
    logic               stall_hit;
    logic               advance;
    logic               accept;
    logic               fault_q;
    logic               goal_q;
    logic [CNT_W-1:0]   cnt_q;

    // A move is only taken when no restart is pending and the episode is not
    // frozen by a fault or by having reached the goal.
    always_comb begin
        accept = step && !restart && !fault_q && !goal_q;
    end

    // Door / zone next-state for a move. This is evaluated every cycle but
    // only committed when the move is accepted. Only the doorstep-to-right
    // move advances the zone, and the zone never moves backwards. iup is
    // deliberately ignored while on the doorstep. Doorstep with zone 4 is
    // not reachable in practice (goal freezes first) but simply holds.
    always_comb begin
        state_d = state_q;
        zone_d  = zone_q;
        advance = 1'b0;
        case (state_q)
            CLOSED: begin
                if (!iup) begin
                    state_d = OPEN;
                end
            end
            OPEN: begin
                if (iup) begin
                    state_d = CLOSED;
                end else if (iright) begin
                    state_d = DOORSTEP;
                end
            end
            DOORSTEP: begin
                if (iright) begin
                    if (zone_q < ZONE_LAST) begin
                        zone_d  = zone_q + 3'd1;
                        state_d = CLOSED;
                        advance = 1'b1;
                    end
                end else begin
                    state_d = OPEN;
                end
            end
            default: begin
                state_d = CLOSED;
            end
        endcase
    end

    // Stall bookkeeping: the increment is computed one bit wider so the
    // comparison against the limit cannot wrap. Hitting the limit on this
    // step is what raises the fault on the same edge.
    always_comb begin
        stall_inc = {1'b0, stall_q} + {{STALL_W{1'b0}}, 1'b1};
        stall_hit = (stall_inc >= STALL_LIM_EXT);
    end

    // Main state register. Reset and restart load identical values; restart
    // outranks step so a simultaneous move is dropped. An advancing move
    // always clears the stall counter, even if the counter was one short of
    // the limit, so advancing never faults. The goal is set on the same edge
    // that the zone becomes 4, and the step counter still counts that move.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CLOSED;
            zone_q  <= 3'd0;
            stall_q <= '0;
            fault_q <= 1'b0;
            goal_q  <= 1'b0;
            cnt_q   <= '0;
        end else if (restart) begin
            state_q <= CLOSED;
            zone_q  <= 3'd0;
            stall_q <= '0;
            fault_q <= 1'b0;
            goal_q  <= 1'b0;
            cnt_q   <= '0;
        end else if (accept) begin
            state_q <= state_d;
            zone_q  <= zone_d;
            if (cnt_q != CNT_MAX) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (advance) begin
                stall_q <= '0;
                if (zone_d == ZONE_LAST) begin
                    goal_q <= 1'b1;
                end
            end else if (stall_hit) begin
                stall_q <= STALL_MAX;
                fault_q <= 1'b1;
            end else begin
                stall_q <= stall_inc[STALL_W-1:0];
            end
        end
    end

    // Output decode, purely from registered state.
    always_comb begin
        zone0    = (zone_q == 3'd0);
        zone1    = (zone_q == 3'd1);
        zone2    = (zone_q == 3'd2);
        zone3    = (zone_q == 3'd3);
        zone4    = (zone_q == 3'd4);
        open     = (state_q != CLOSED);
        doorstep = (state_q == DOORSTEP);
        fault    = fault_q;
        goal     = goal_q;
        step_cnt = cnt_q;
    end

endmodule

// File: tb/tb_passageway_ctrl.sv
// ---------------------------------------------------------------------------
// tb_passageway_ctrl
//
// Purpose:
//   Self-checking bench for passageway_ctrl. Three instances share the same
//   stimulus: A uses default parameters, B uses STALL_LIMIT=4, C uses CNT_W=3.
//   A table of hand-computed vectors covers the happy path and back-off, hand
//   sequences cover stall fault, restart priority, saturation and async
//   reset, and a randomized run compares all instances against a high-level
//   corridor model.
// ---------------------------------------------------------------------------
module tb_passageway_ctrl;

    logic clk;
    logic rst_n;
    logic step;
    logic restart;
    logic iup;
    logic iright;

    logic a_z0, a_z1, a_z2, a_z3, a_z4, a_open, a_ds, a_fault, a_goal;
    logic b_z0, b_z1, b_z2, b_z3, b_z4, b_open, b_ds, b_fault, b_goal;
    logic c_z0, c_z1, c_z2, c_z3, c_z4, c_open, c_ds, c_fault, c_goal;
    logic [7:0] a_cnt;
    logic [7:0] b_cnt;
    logic [2:0] c_cnt;

    logic [16:0] obs_a;
    logic [16:0] obs_b;
    logic [16:0] obs_c;

    int checks;
    int failures;

    // Corridor model: door open flag, on-doorstep flag, zone number and a
    // count of steps since the last advance.
    typedef struct {
        int zone;
        bit is_open;
        bit on_step;
        int stall;
        bit fault;
        bit goal;
        int cnt;
    } model_t;

    typedef struct {
        bit restart;
        bit step;
        bit up;
        bit right;
        int zone;
        bit is_open;
        bit on_step;
        bit fault;
        bit goal;
        int cnt;
    } vec_t;

    model_t m_a;
    model_t m_b;
    model_t m_c;
    vec_t   vecs[$];

    passageway_ctrl dut_a (
        .clk(clk), .rst_n(rst_n), .step(step), .restart(restart),
        .iup(iup), .iright(iright),
        .zone0(a_z0), .zone1(a_z1), .zone2(a_z2), .zone3(a_z3), .zone4(a_z4),
        .open(a_open), .doorstep(a_ds), .fault(a_fault), .goal(a_goal),
        .step_cnt(a_cnt)
    );

    passageway_ctrl #(.STALL_LIMIT(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .step(step), .restart(restart),
        .iup(iup), .iright(iright),
        .zone0(b_z0), .zone1(b_z1), .zone2(b_z2), .zone3(b_z3), .zone4(b_z4),
        .open(b_open), .doorstep(b_ds), .fault(b_fault), .goal(b_goal),
        .step_cnt(b_cnt)
    );

    passageway_ctrl #(.CNT_W(3)) dut_c (
        .clk(clk), .rst_n(rst_n), .step(step), .restart(restart),
        .iup(iup), .iright(iright),
        .zone0(c_z0), .zone1(c_z1), .zone2(c_z2), .zone3(c_z3), .zone4(c_z4),
        .open(c_open), .doorstep(c_ds), .fault(c_fault), .goal(c_goal),
        .step_cnt(c_cnt)
    );

    // Packed views of each instance: zones, open, doorstep, fault, goal, count.
    assign obs_a = {a_z4, a_z3, a_z2, a_z1, a_z0, a_open, a_ds, a_fault, a_goal, a_cnt};
    assign obs_b = {b_z4, b_z3, b_z2, b_z1, b_z0, b_open, b_ds, b_fault, b_goal, b_cnt};
    assign obs_c = {c_z4, c_z3, c_z2, c_z1, c_z0, c_open, c_ds, c_fault, c_goal, 5'b0, c_cnt};

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run always terminates.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic model_t reset_model();
        model_t r;
        r.zone    = 0;
        r.is_open = 1'b0;
        r.on_step = 1'b0;
        r.stall   = 0;
        r.fault   = 1'b0;
        r.goal    = 1'b0;
        r.cnt     = 0;
        return r;
    endfunction

    // One edge of the corridor rules for a given stall limit and count cap.
    function automatic model_t model_next(model_t s, bit rs, bit st, bit up, bit rt,
                                          int limit, int cnt_max);
        model_t n;
        bit advanced;
        n = s;
        advanced = 1'b0;
        if (rs) return reset_model();
        if (!st || s.fault || s.goal) return s;
        n.cnt = (s.cnt < cnt_max) ? s.cnt + 1 : cnt_max;
        if (s.on_step) begin
            if (rt) begin
                if (s.zone < 4) begin
                    n.zone    = s.zone + 1;
                    n.on_step = 1'b0;
                    n.is_open = 1'b0;
                    advanced  = 1'b1;
                end
            end else begin
                n.on_step = 1'b0;
            end
        end else if (s.is_open) begin
            if (up) n.is_open = 1'b0;
            else if (rt) n.on_step = 1'b1;
        end else if (!up) begin
            n.is_open = 1'b1;
        end
        if (advanced) begin
            n.stall = 0;
            if (n.zone == 4) n.goal = 1'b1;
        end else begin
            n.stall = s.stall + 1;
            if (n.stall >= limit) begin
                n.stall = limit;
                n.fault = 1'b1;
            end
        end
        return n;
    endfunction

    function automatic logic [16:0] make_view(int zone, bit op, bit ds, bit f, bit g, int cnt);
        logic [4:0] onehot;
        onehot = 5'(1 << zone);
        return {onehot, op, ds, f, g, 8'(cnt)};
    endfunction

    function automatic logic [16:0] model_view(model_t m);
        return make_view(m.zone, m.is_open, m.on_step, m.fault, m.goal, m.cnt);
    endfunction

    // Drive one cycle of inputs, advance the models on the edge, and settle
    // one unit after the edge so outputs are sampled away from it.
    task automatic applyStimulus(input bit rs, input bit st, input bit up, input bit rt);
        restart = rs;
        step    = st;
        iup     = up;
        iright  = rt;
        @(posedge clk);
        m_a = model_next(m_a, rs, st, up, rt, 16, 255);
        m_b = model_next(m_b, rs, st, up, rt, 4, 255);
        m_c = model_next(m_c, rs, st, up, rt, 16, 7);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [16:0] act, input logic [16:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic check_models(input string tag);
        checkOutput({tag, "_A"}, obs_a, model_view(m_a));
        checkOutput({tag, "_B"}, obs_b, model_view(m_b));
        checkOutput({tag, "_C"}, obs_c, model_view(m_c));
    endtask

    function automatic vec_t mk_vec(bit rs, bit st, bit up, bit rt, int zone,
                                    bit op, bit ds, bit f, bit g, int cnt);
        vec_t v;
        v.restart = rs; v.step = st; v.up = up; v.right = rt;
        v.zone = zone; v.is_open = op; v.on_step = ds;
        v.fault = f; v.goal = g; v.cnt = cnt;
        return v;
    endfunction

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        step     = 1'b0;
        restart  = 1'b0;
        iup      = 1'b0;
        iright   = 1'b0;
        m_a = reset_model();
        m_b = reset_model();
        m_c = reset_model();

        // Table: happy path on instance A, then restart+step, then back-off.
        vecs.push_back(mk_vec(0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
        for (int z = 0; z < 4; z++) begin
            vecs.push_back(mk_vec(0, 1, 0, 0, z, 1, 0, 0, 0, 3 * z + 1));
            vecs.push_back(mk_vec(0, 1, 0, 1, z, 1, 1, 0, 0, 3 * z + 2));
            vecs.push_back(mk_vec(0, 1, 0, 1, z + 1, 0, 0, 0, z == 3, 3 * z + 3));
        end
        vecs.push_back(mk_vec(0, 1, 0, 0, 4, 0, 0, 0, 1, 12));
        vecs.push_back(mk_vec(0, 1, 0, 1, 4, 0, 0, 0, 1, 12));
        vecs.push_back(mk_vec(1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk_vec(0, 1, 0, 0, 0, 1, 0, 0, 0, 1));
        vecs.push_back(mk_vec(0, 1, 0, 1, 0, 1, 1, 0, 0, 2));
        vecs.push_back(mk_vec(0, 1, 1, 0, 0, 1, 0, 0, 0, 3));
        vecs.push_back(mk_vec(0, 1, 1, 0, 0, 0, 0, 0, 0, 4));
        vecs.push_back(mk_vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 4));

        // Reset state on all instances.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_A", obs_a, make_view(0, 0, 0, 0, 0, 0));
        checkOutput("reset_B", obs_b, make_view(0, 0, 0, 0, 0, 0));
        checkOutput("reset_C", obs_c, make_view(0, 0, 0, 0, 0, 0));
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].restart, vecs[i].step, vecs[i].up, vecs[i].right);
            checkOutput($sformatf("vec%0d", i), obs_a,
                        make_view(vecs[i].zone, vecs[i].is_open, vecs[i].on_step,
                                  vecs[i].fault, vecs[i].goal, vecs[i].cnt));
        end

        // Stall fault on B: four non-advancing steps, fifth is ignored.
        applyStimulus(1, 0, 0, 0);
        for (int k = 1; k <= 3; k++) applyStimulus(0, 1, 1, 0);
        checkOutput("stall3_B", obs_b, make_view(0, 0, 0, 0, 0, 3));
        applyStimulus(0, 1, 1, 0);
        checkOutput("stall4_B", obs_b, make_view(0, 0, 0, 1, 0, 4));
        applyStimulus(0, 1, 0, 0);
        checkOutput("stall_frozen_B", obs_b, make_view(0, 0, 0, 1, 0, 4));
        checkOutput("stall_nofault_A", obs_a, make_view(0, 1, 0, 0, 0, 5));
        applyStimulus(1, 1, 0, 0);
        checkOutput("restart_clears_fault_B", obs_b, make_view(0, 0, 0, 0, 0, 0));

        // Advance on the step that would hit the limit: no fault, counter clears.
        applyStimulus(0, 1, 1, 0);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 1, 0, 1);
        applyStimulus(0, 1, 0, 1);
        checkOutput("advance_at_limit_B", obs_b, make_view(1, 0, 0, 0, 0, 4));
        for (int k = 0; k < 3; k++) applyStimulus(0, 1, 1, 0);
        checkOutput("stall_after_clear_B", obs_b, make_view(1, 0, 0, 0, 0, 7));
        applyStimulus(0, 1, 1, 0);
        checkOutput("fault_after_clear_B", obs_b, make_view(1, 0, 0, 1, 0, 8));

        // Goal reached while the stall counter sits one short of the limit.
        applyStimulus(1, 0, 0, 0);
        for (int z = 0; z < 3; z++) begin
            applyStimulus(0, 1, 0, 0);
            applyStimulus(0, 1, 0, 1);
            applyStimulus(0, 1, 0, 1);
        end
        checkOutput("zone3_A", obs_a, make_view(3, 0, 0, 0, 0, 9));
        applyStimulus(0, 1, 1, 0);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 1, 0, 1);
        applyStimulus(0, 1, 0, 1);
        checkOutput("goal_at_limit_B", obs_b, make_view(4, 0, 0, 0, 1, 13));

        // Restart with step at zone 3 without goal.
        applyStimulus(1, 0, 0, 0);
        for (int z = 0; z < 3; z++) begin
            applyStimulus(0, 1, 0, 0);
            applyStimulus(0, 1, 0, 1);
            applyStimulus(0, 1, 0, 1);
        end
        applyStimulus(1, 1, 0, 1);
        checkOutput("restart_priority_A", obs_a, make_view(0, 0, 0, 0, 0, 0));

        // Counter saturation on C: ten alternating down/up moves.
        for (int k = 0; k < 10; k++) begin
            applyStimulus(0, 1, k[0], 0);
            if (k == 6) checkOutput("cnt7_C", obs_c, make_view(0, 1, 0, 0, 0, 7));
        end
        checkOutput("cnt_sat_C", obs_c, make_view(0, 0, 0, 0, 0, 7));

        // Asynchronous reset mid-episode at zone 2 on the doorstep.
        applyStimulus(1, 0, 0, 0);
        for (int z = 0; z < 2; z++) begin
            applyStimulus(0, 1, 0, 0);
            applyStimulus(0, 1, 0, 1);
            applyStimulus(0, 1, 0, 1);
        end
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 1, 0, 1);
        checkOutput("zone2_doorstep_A", obs_a, make_view(2, 1, 1, 0, 0, 8));
        step = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_A", obs_a, make_view(0, 0, 0, 0, 0, 0));
        checkOutput("async_reset_C", obs_c, make_view(0, 0, 0, 0, 0, 0));
        m_a = reset_model();
        m_b = reset_model();
        m_c = reset_model();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Randomized run against the corridor model.
        for (int n = 0; n < 600; n++) begin
            applyStimulus($urandom_range(0, 24) == 0, $urandom_range(0, 3) != 0,
                          $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1);
            check_models($sformatf("rand%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/passageway_ctrl.md
# passageway_ctrl

Reference controller for the passageway benchmark. Each accepted step consumes one tester move (`iup`, `iright`) and updates a registered corridor state: current zone, door-open and doorstep flags, fault and goal. Its outputs drive the `controllable_*` inputs of the passageway requirement monitor, so a fault-free run produces a monitor trace with `error` low that reaches `objective`. It sits on the SUT side of the RL test harness, between the tester stimulus and the monitor.

## Interface
- `STALL_LIMIT`, default 16: consecutive non-advancing accepted steps before `fault` is raised (valid range ≥ 1).
- `CNT_W`, default 8: width of the step counter.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `step` in 1: qualifies `iup`/`iright` for one move per cycle.
- `restart` in 1: synchronous episode restart.
- `iup` in 1: 1 = up, 0 = down.
- `iright` in 1: 1 = right, 0 = left.
- `zone0`..`zone4` out 1 each: one-hot current zone.
- `open` out 1: door open.
- `doorstep` out 1: standing on the doorstep.
- `fault` out 1: sticky stall fault.
- `goal` out 1: sticky, zone 4 reached.
- `step_cnt` out CNT_W: accepted steps this episode, saturating.

## Operation
- State register: FSM `CLOSED`/`OPEN`/`DOORSTEP`, 3-bit zone index 0..4, stall counter of width clog2(STALL_LIMIT+1), `fault`, `goal`, `step_cnt`.
- Outputs are decoded from registers:
  - `open` = state ≠ CLOSED.
  - `doorstep` = state == DOORSTEP.
  - `zoneN` = (zone index == N).
- Accepted step: `step`=1, `restart`=0, `fault`=0, `goal`=0.
- Frozen: `fault` or `goal` set. All registers hold and steps are ignored until restart or reset.
- Transitions on an accepted step:
  - CLOSED, `iup`=1: stay CLOSED.
  - CLOSED, `iup`=0: go to OPEN.
  - OPEN, `iup`=1: go to CLOSED.
  - OPEN, `iup`=0, `iright`=1: go to DOORSTEP.
  - OPEN, `iup`=0, `iright`=0: stay OPEN.
  - DOORSTEP, `iright`=1, zone < 4: zone +1, go to CLOSED. This is an advancing step.
  - DOORSTEP, `iright`=0: zone unchanged, go to OPEN. `iup` is ignored in DOORSTEP.
  - DOORSTEP with zone 4 is unreachable because `goal` freezes first. If reached, hold.
- Zone never decrements and only changes on an advancing step.
- `goal` is set on the same edge that zone becomes 4.
- Stall counter:
  - Cleared on an advancing step.
  - Otherwise +1 per accepted step.
  - When the increment reaches STALL_LIMIT, set `fault` on that same edge. The counter saturates at STALL_LIMIT.
- `step_cnt`: +1 per accepted step, including the step that sets `fault` or `goal`. Saturates at 2^CNT_W−1.
- `restart`=1 (synchronous, priority over `step`) loads reset values on the next edge. It also clears `fault` and `goal`.

## Timing
- Reset values:
  - `zone0`=1, `zone1`..`zone4`=0.
  - `open`=0, `doorstep`=0, `fault`=0, `goal`=0, `step_cnt`=0.
  - Stall counter 0, FSM CLOSED, zone index 0.
- `rst_n` low acts immediately, regardless of `clk`. An accepted step on the edge where reset is released is still ignored until `rst_n` is high at the sampling edge.
- Latency: all outputs reflect a step on the edge that samples it. They are visible in the following cycle and no combinational path from inputs to outputs exists.
- One move per cycle. Back-to-back `step` is legal with no bubbles.
- Simultaneous events:
  - `restart` with `step`: restart wins and the step is dropped.
  - Advancing step on the stall-limit count: the advance wins, the counter clears and no fault is raised.
  - Zone reaches 4 while stall is at its limit: `goal`=1, `fault`=0.
- `step`=0: every register holds.

## Test plan
- Reset: drive `rst_n`=0 mid-sequence at zone 2 / DOORSTEP -> outputs go to reset values immediately without a clock edge; `zone0`=1, `step_cnt`=0.
- Happy path: 4× (down-left, down-right, down-right) as step triples, 12 steps -> `zone4`=1, `goal`=1, `open`=0, `step_cnt`=12, `fault`=0. Further steps leave all outputs unchanged.
- Stall fault (STALL_LIMIT=4): 4 steps with `iup`=1 in CLOSED -> `fault`=1 after step 4, `step_cnt`=4, `zone0`=1. A 5th step changes nothing.
- Back-off: CLOSED, down, down-right (`doorstep`=1), left -> OPEN, `doorstep`=0, zone 0. Then up -> `open`=0, stall counter = 4 → 3rd+ step path verified by later fault timing.
- Restart priority: at zone 3 with `goal`=0, assert `restart` and `step` together -> next cycle `zone0`=1, `open`=0, `step_cnt`=0. Also assert `restart` while `fault`=1 -> `fault` clears.
- Saturation (CNT_W=3): 10 steps alternating down/up in zone 0 with STALL_LIMIT=16 -> `step_cnt`=7 and holds, `fault`=0.
